pipe_fetch_if: RTL and testbench

//  IF stage and IF/ID register; consumes control outputs of the ID-stage control unit (pcsource, stall).

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_next_pc.sv | 30 +++
 rtl/pipe_fetch_if.sv | 185 ++++++++++++++++++
 tb/tb_pipe_fetch_if.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline fetch stage.
//   - pcsource encodings produced by the ID-stage control unit
//   - fetch state machine encoding
//   - default reset PC and bubble instruction word
//   - helper to recognise a control-flow redirect
package pipe_pkg;

    localparam logic [1:0] PCSRC_PC4    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JR     = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        FETCH   = 2'b01,
        DISCARD = 2'b10,
        HOLD    = 2'b11
    } fetch_state_t;

    // Any non-sequential pcsource replaces the fall-through PC.
    function automatic logic is_redirect(input logic [1:0] pcsource);
        return |pcsource;
    endfunction

endpackage

// File: rtl/pipe_next_pc.sv
// pipe_next_pc: combinational next-PC selector.
//   i_pcsource  [1:0]  00 pc+4, 01 branch, 10 register, 11 jump
//   i_pc4       [31:0] sequential successor
//   i_bpc       [31:0] branch target
//   i_rpc       [31:0] jr target
//   i_jpc       [31:0] j/jal target
//   o_next_pc   [31:0] selected address (targets passed through unmodified)
module pipe_next_pc
    import pipe_pkg::*;
(
    input  logic [1:0]  i_pcsource,
    input  logic [31:0] i_pc4,
    input  logic [31:0] i_bpc,
    input  logic [31:0] i_rpc,
    input  logic [31:0] i_jpc,
    output logic [31:0] o_next_pc
);

    always_comb begin
        o_next_pc = i_pc4;
        case (i_pcsource)
            PCSRC_PC4:    o_next_pc = i_pc4;
            PCSRC_BRANCH: o_next_pc = i_bpc;
            PCSRC_JR:     o_next_pc = i_rpc;
            PCSRC_JUMP:   o_next_pc = i_jpc;
            default:      o_next_pc = i_pc4;
        endcase
    end

endmodule

// File: rtl/pipe_fetch_if.sv
// pipe_fetch_if: IF stage plus IF/ID pipeline register.
// Owns the PC, fetches over a req/ready instruction-memory handshake,
// squashes wrong-path fetches on redirect and buffers a returned word
// while the control unit stalls ID.
//   clock       rising-edge clock
//   resetn      synchronous reset, active low
//   pcsource    [1:0]  next-PC select from control unit (nonzero = redirect)
//   stall       hold ID and PC
//   bpc/rpc/jpc [31:0] branch / jr / jump targets
//   imem_req    fetch request, held until imem_ready
//   imem_addr   [31:0] fetch address (always the PC)
//   imem_rdata  [31:0] instruction word, valid with imem_ready
//   imem_ready  response strobe, ignored while imem_req=0
//   id_inst     [31:0] IF/ID instruction
//   id_pc4      [31:0] pc+4 belonging to id_inst
//   id_bubble   ID holds a bubble
//   if_pc       [31:0] current PC
module pipe_fetch_if
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic        stall,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    output logic        id_bubble,
    output logic [31:0] if_pc
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_tgt;
    logic [31:0]  r_buf;
    logic [31:0]  r_id_inst;
    logic [31:0]  r_id_pc4;
    logic         r_id_bubble;

    fetch_state_t w_state_next;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_tgt_next;
    logic [31:0]  w_buf_next;
    logic [31:0]  w_id_inst_next;
    logic [31:0]  w_id_pc4_next;
    logic         w_id_bubble_next;

    logic [31:0]  w_pc4;
    logic [31:0]  w_target;
    logic         w_req;
    logic         w_ready;
    logic         w_redirect;

    // Wraps modulo 2^32 naturally.
    assign w_pc4      = r_pc + 32'd4;
    assign w_req      = (r_state == FETCH) || (r_state == DISCARD);
    // A strobe without an outstanding request carries no data.
    assign w_ready    = imem_ready & w_req;
    assign w_redirect = is_redirect(pcsource);

    pipe_next_pc u_next_pc (
        .i_pcsource (pcsource),
        .i_pc4      (w_pc4),
        .i_bpc      (bpc),
        .i_rpc      (rpc),
        .i_jpc      (jpc),
        .o_next_pc  (w_target)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_tgt       <= 32'd0;
            r_buf       <= 32'd0;
            r_id_inst   <= NOP_INST;
            r_id_pc4    <= 32'd0;
            r_id_bubble <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_tgt       <= w_tgt_next;
            r_buf       <= w_buf_next;
            r_id_inst   <= w_id_inst_next;
            r_id_pc4    <= w_id_pc4_next;
            r_id_bubble <= w_id_bubble_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_tgt_next       = r_tgt;
        w_buf_next       = r_buf;
        w_id_inst_next   = r_id_inst;
        w_id_pc4_next    = r_id_pc4;
        w_id_bubble_next = r_id_bubble;

        case (r_state)
            IDLE: begin
                w_state_next     = FETCH;
                w_id_inst_next   = NOP_INST;
                w_id_bubble_next = 1'b1;
            end

            FETCH: begin
                if (w_redirect) begin
                    w_id_inst_next   = NOP_INST;
                    w_id_bubble_next = 1'b1;
                    if (w_ready) begin
                        w_pc_next = w_target;
                    end else begin
                        // The address must stay put until the outstanding
                        // request completes, so park the target.
                        w_tgt_next   = w_target;
                        w_state_next = DISCARD;
                    end
                end else if (stall) begin
                    if (w_ready) begin
                        w_buf_next   = imem_rdata;
                        w_state_next = HOLD;
                    end
                end else if (w_ready) begin
                    w_id_inst_next   = imem_rdata;
                    w_id_pc4_next    = w_pc4;
                    w_id_bubble_next = 1'b0;
                    w_pc_next        = w_pc4;
                end else begin
                    w_id_inst_next   = NOP_INST;
                    w_id_bubble_next = 1'b1;
                end
            end

            DISCARD: begin
                // ID already holds a bubble from the redirect, so a further
                // redirect here has nothing to squash and is ignored.
                if (!stall) begin
                    w_id_inst_next   = NOP_INST;
                    w_id_bubble_next = 1'b1;
                end
                if (w_ready) begin
                    w_pc_next    = r_tgt;
                    w_state_next = FETCH;
                end
            end

            HOLD: begin
                if (w_redirect) begin
                    w_pc_next        = w_target;
                    w_id_inst_next   = NOP_INST;
                    w_id_bubble_next = 1'b1;
                    w_state_next     = FETCH;
                end else if (!stall) begin
                    // PC still points at the buffered word.
                    w_id_inst_next   = r_buf;
                    w_id_pc4_next    = w_pc4;
                    w_id_bubble_next = 1'b0;
                    w_pc_next        = w_pc4;
                    w_state_next     = FETCH;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign id_inst   = r_id_inst;
    assign id_pc4    = r_id_pc4;
    assign id_bubble = r_id_bubble;
    assign if_pc     = r_pc;

endmodule

// File: tb/tb_pipe_fetch_if.sv
module tb_pipe_fetch_if;

    logic        clock;
    logic        resetn;
    logic [1:0]  pcsource;
    logic        stall;
    logic [31:0] bpc;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic        imem_ready;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;
    logic        id_bubble;
    logic [31:0] if_pc;

    logic        wr_imem_req;
    logic [31:0] wr_imem_addr;
    logic [31:0] wr_imem_rdata;
    logic [31:0] wr_id_inst;
    logic [31:0] wr_id_pc4;
    logic        wr_id_bubble;
    logic [31:0] wr_if_pc;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];

    // Memory model: each word's content equals its address.
    assign imem_rdata    = imem_addr;
    assign wr_imem_rdata = wr_imem_addr;

    pipe_fetch_if dut (
        .clock      (clock),
        .resetn     (resetn),
        .pcsource   (pcsource),
        .stall      (stall),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .id_inst    (id_inst),
        .id_pc4     (id_pc4),
        .id_bubble  (id_bubble),
        .if_pc      (if_pc)
    );

    pipe_fetch_if #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clock      (clock),
        .resetn     (resetn),
        .pcsource   (pcsource),
        .stall      (stall),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .imem_req   (wr_imem_req),
        .imem_addr  (wr_imem_addr),
        .imem_rdata (wr_imem_rdata),
        .imem_ready (imem_ready),
        .id_inst    (wr_id_inst),
        .id_pc4     (wr_id_pc4),
        .id_bubble  (wr_id_bubble),
        .if_pc      (wr_if_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_id(input logic [31:0] inst, input logic [31:0] pc4);
        exp_q.push_back({inst, pc4});
    endtask

    // Monitor: every newly loaded non-bubble IF/ID entry is one transaction.
    logic        mon_en = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_inst = 32'd0;
    logic [31:0] prev_pc4 = 32'd0;

    always @(negedge clock) begin
        if (mon_en) begin
            if (id_bubble === 1'b1) begin
                chk("bubble_inst", id_inst, 32'h0000_0000);
            end else if (id_bubble === 1'b0 &&
                         (!prev_valid || id_inst !== prev_inst || id_pc4 !== prev_pc4)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL id_unexpected actual=%h/%h required=none", id_inst, id_pc4);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("id_inst", id_inst, e[63:32]);
                    chk("id_pc4", id_pc4, e[31:0]);
                end
            end
            prev_valid = (id_bubble === 1'b0);
            prev_inst  = id_inst;
            prev_pc4   = id_pc4;
        end
    end

    initial begin
        resetn     = 1'b0;
        pcsource   = 2'b00;
        stall      = 1'b0;
        bpc        = 32'd0;
        rpc        = 32'd0;
        jpc        = 32'd0;
        imem_ready = 1'b1;

        repeat (2) tick();
        chk("rst_bubble", {31'd0, id_bubble}, 32'd1);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_inst", id_inst, 32'd0);
        chk("rst_pc4", id_pc4, 32'd0);
        chk("wrap_rst_pc", wr_if_pc, 32'hFFFF_FFFC);
        mon_en = 1'b1;

        // Zero-wait stream
        resetn = 1'b1;
        expect_id(32'h0, 32'h4);
        expect_id(32'h4, 32'h8);
        expect_id(32'h8, 32'hC);
        expect_id(32'hC, 32'h10);
        tick(); // E1: IDLE -> FETCH
        chk("e1_req", {31'd0, imem_req}, 32'd1);
        chk("e1_addr", imem_addr, 32'h0);
        chk("e1_bubble", {31'd0, id_bubble}, 32'd1);
        chk("wrap_e1_addr", wr_imem_addr, 32'hFFFF_FFFC);
        tick(); // E2
        chk("wrap_e2_inst", wr_id_inst, 32'hFFFF_FFFC);
        chk("wrap_e2_pc4", wr_id_pc4, 32'h0);
        chk("wrap_e2_addr", wr_imem_addr, 32'h0);
        tick(); // E3: pc=8, ID=4
        chk("wrap_e3_inst", wr_id_inst, 32'h0);
        chk("wrap_e3_pc4", wr_id_pc4, 32'h4);

        // Stall two cycles with ready high
        stall = 1'b1;
        tick(); // E4: word 8 buffered, HOLD
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_pc", if_pc, 32'h8);
        chk("hold_inst", id_inst, 32'h4);
        tick(); // E5
        chk("hold2_inst", id_inst, 32'h4);
        stall = 1'b0;
        tick(); // E6: ID=8
        tick(); // E7: ID=12, pc=16

        // Branch with ready high
        pcsource = 2'b01;
        bpc      = 32'h40;
        expect_id(32'h40, 32'h44);
        tick(); // E8
        pcsource = 2'b00;
        chk("br_bubble", {31'd0, id_bubble}, 32'd1);
        chk("br_addr", imem_addr, 32'h40);
        tick(); // E9: ID=0x40

        // Jump to 0x10 to set up the mid-request case
        pcsource = 2'b11;
        jpc      = 32'h10;
        tick(); // E10
        chk("j10_addr", imem_addr, 32'h10);

        // Redirect while the request at 0x10 is outstanding
        imem_ready = 1'b0;
        jpc        = 32'h100;
        tick(); // E11: -> DISCARD
        chk("disc_addr1", imem_addr, 32'h10);
        chk("disc_req1", {31'd0, imem_req}, 32'd1);
        pcsource = 2'b10;
        rpc      = 32'h200;
        tick(); // E12: redirect ignored
        chk("disc_addr2", imem_addr, 32'h10);
        pcsource = 2'b00;
        tick(); // E13
        chk("disc_addr3", imem_addr, 32'h10);
        imem_ready = 1'b1;
        expect_id(32'h100, 32'h104);
        tick(); // E14: data dropped, pc=0x100
        chk("disc_done_addr", imem_addr, 32'h100);
        chk("disc_done_bubble", {31'd0, id_bubble}, 32'd1);
        tick(); // E15: ID=0x100

        // Wait state in normal flow
        imem_ready = 1'b0;
        tick(); // E16
        chk("wait_bubble", {31'd0, id_bubble}, 32'd1);
        chk("wait_pc", if_pc, 32'h104);
        imem_ready = 1'b1;
        expect_id(32'h104, 32'h108);
        tick(); // E17

        // Reset while in HOLD
        stall = 1'b1;
        tick(); // E18: HOLD
        chk("rh_req", {31'd0, imem_req}, 32'd0);
        resetn = 1'b0;
        tick(); // E19: reset
        resetn = 1'b1;
        stall  = 1'b0;
        chk("rh_bubble", {31'd0, id_bubble}, 32'd1);
        chk("rh_req0", {31'd0, imem_req}, 32'd0);
        chk("rh_pc", if_pc, 32'h0);
        expect_id(32'h0, 32'h4);
        expect_id(32'h4, 32'h8);
        tick(); // E20: stray ready in IDLE has no effect
        chk("rh_idle_bubble", {31'd0, id_bubble}, 32'd1);
        chk("rh_idle_pc", if_pc, 32'h0);
        tick(); // E21: ID=0
        tick(); // E22: ID=4
        imem_ready = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        #1;
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
